// File: rtl/mlp_sequencer.sv
// mlp_sequencer
//   Sequences NUM_LAYERS external layer engines through one shared input
//   address bus, then runs an argmax over the final layer's signed scores.
//   A layer that never reports done trips a timeout: the sticky error flag is
//   set and the sequencer returns to IDLE. The result is offered on a
//   valid/ready handshake. Abort cancels any operation.
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start, abort      begin inference (IDLE only) / cancel (any state)
//   layer_run         one-hot run strobe to the layer being fed
//   layer_done        per-layer done (level or pulse); only the active bit is used
//   addr              shared input index for the active layer
//   scores            final-layer scores, class 0 in the LSBs, signed
//   busy, error       not-IDLE indicator / sticky timeout flag
//   result_valid/ready, class_idx, class_score   argmax result handshake
module mlp_sequencer #(
  parameter int                       NUM_LAYERS   = 3,
  parameter logic [NUM_LAYERS*16-1:0] LAYER_INPUTS = {16'd32, 16'd128, 16'd784},
  parameter int                       ADDR_W       = 10,
  parameter int                       NUM_CLASSES  = 10,
  parameter int                       SCORE_W      = 16,
  parameter int                       TIMEOUT      = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic [NUM_LAYERS-1:0]            layer_run,
  input  logic [NUM_LAYERS-1:0]            layer_done,
  output logic [ADDR_W-1:0]                addr,
  input  logic [NUM_CLASSES*SCORE_W-1:0]   scores,
  output logic                             busy,
  output logic                             error,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [$clog2(NUM_CLASSES)-1:0]   class_idx,
  output logic [SCORE_W-1:0]               class_score
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ARGMAX = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]                       state_reg, state_next;
  logic [LW-1:0]                    layer_reg, layer_next;
  logic [ADDR_W-1:0]                addr_reg, addr_next;
  logic [TW-1:0]                    wait_reg, wait_next;
  logic [IDX_W-1:0]                 cmp_reg, cmp_next;
  logic [IDX_W-1:0]                 best_idx_reg, best_idx_next;
  logic signed [SCORE_W-1:0]        best_score_reg, best_score_next;
  logic [NUM_CLASSES*SCORE_W-1:0]   score_lat_reg, score_lat_next;
  logic                             error_reg, error_next;
  logic [IDX_W-1:0]                 class_idx_reg, class_idx_next;
  logic [SCORE_W-1:0]               class_score_reg, class_score_next;

  logic [15:0]               len_arr   [NUM_LAYERS];
  logic signed [SCORE_W-1:0] score_arr [NUM_CLASSES];
  logic [ADDR_W-1:0]         last_addr;

  // Unpack the parameter and the latched score vector into indexable arrays.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    assign len_arr[gi]   = LAYER_INPUTS[gi*16 +: 16];
    assign layer_run[gi] = (state_reg == S_RUN) && (layer_reg == LW'(gi));
  end

  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
    assign score_arr[gi] = score_lat_reg[gi*SCORE_W +: SCORE_W];
  end

  assign last_addr = ADDR_W'(len_arr[layer_reg] - 16'd1);

  always_comb begin
    state_next       = state_reg;
    layer_next       = layer_reg;
    addr_next        = addr_reg;
    wait_next        = wait_reg;
    cmp_next         = cmp_reg;
    best_idx_next    = best_idx_reg;
    best_score_next  = best_score_reg;
    score_lat_next   = score_lat_reg;
    error_next       = error_reg;
    class_idx_next   = class_idx_reg;
    class_score_next = class_score_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          layer_next = '0;
          addr_next  = '0;
          error_next = 1'b0;
        end
      end
      S_RUN: begin
        if (addr_reg == last_addr) begin
          state_next = S_WAIT;
          addr_next  = '0;
          wait_next  = '0;
        end else begin
          addr_next = addr_reg + ADDR_W'(1);
        end
      end
      S_WAIT: begin
        // A done on the timeout cycle still counts as success.
        if (layer_done[layer_reg]) begin
          wait_next = '0;
          if (layer_reg == LW'(NUM_LAYERS - 1)) begin
            state_next     = S_ARGMAX;
            cmp_next       = '0;
            score_lat_next = scores;
          end else begin
            state_next = S_RUN;
            layer_next = layer_reg + LW'(1);
          end
        end else if (wait_reg == TW'(TIMEOUT - 1)) begin
          state_next = S_IDLE;
          error_next = 1'b1;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + TW'(1);
        end
      end
      S_ARGMAX: begin
        // Strict greater-than so a tie keeps the earlier (lower) index.
        if (cmp_reg == '0 || score_arr[cmp_reg] > best_score_reg) begin
          best_score_next = score_arr[cmp_reg];
          best_idx_next   = cmp_reg;
        end
        if (cmp_reg == IDX_W'(NUM_CLASSES - 1)) begin
          state_next       = S_HOLD;
          class_idx_next   = best_idx_next;
          class_score_next = best_score_next;
        end else begin
          cmp_next = cmp_reg + IDX_W'(1);
        end
      end
      S_HOLD: begin
        if (result_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Abort wins over everything; the published result and error are kept.
    if (abort) begin
      state_next       = S_IDLE;
      addr_next        = '0;
      wait_next        = '0;
      error_next       = error_reg;
      class_idx_next   = class_idx_reg;
      class_score_next = class_score_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      layer_reg       <= '0;
      addr_reg        <= '0;
      wait_reg        <= '0;
      cmp_reg         <= '0;
      best_idx_reg    <= '0;
      best_score_reg  <= '0;
      score_lat_reg   <= '0;
      error_reg       <= 1'b0;
      class_idx_reg   <= '0;
      class_score_reg <= '0;
    end else begin
      state_reg       <= state_next;
      layer_reg       <= layer_next;
      addr_reg        <= addr_next;
      wait_reg        <= wait_next;
      cmp_reg         <= cmp_next;
      best_idx_reg    <= best_idx_next;
      best_score_reg  <= best_score_next;
      score_lat_reg   <= score_lat_next;
      error_reg       <= error_next;
      class_idx_reg   <= class_idx_next;
      class_score_reg <= class_score_next;
    end
  end

  assign addr         = addr_reg;
  assign busy         = (state_reg != S_IDLE);
  assign error        = error_reg;
  assign result_valid = (state_reg == S_HOLD);
  assign class_idx    = class_idx_reg;
  assign class_score  = class_score_reg;

endmodule

// File: tb/tb_mlp_sequencer.sv
// tb_mlp_sequencer
//   Directed bench for mlp_sequencer with LAYER_INPUTS={4,8,16}, NUM_CLASSES=10,
//   TIMEOUT=20. A table of score vectors with hand-computed argmax results is
//   run through full inferences; hand-written sequences cover reset, timeout,
//   abort and result backpressure.
module tb_mlp_sequencer;

  localparam int NL = 3;
  localparam int NC = 10;
  localparam int SW = 16;
  localparam int AW = 5;
  localparam int TO = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NL-1:0]     layer_run;
  logic [NL-1:0]     layer_done = '0;
  logic [AW-1:0]     addr;
  logic [NC*SW-1:0]  scores = '0;
  logic              busy;
  logic              error;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [3:0]        class_idx;
  logic [SW-1:0]     class_score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mlp_sequencer #(
    .NUM_LAYERS  (NL),
    .LAYER_INPUTS({16'd4, 16'd8, 16'd16}),
    .ADDR_W      (AW),
    .NUM_CLASSES (NC),
    .SCORE_W     (SW),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .layer_run   (layer_run),
    .layer_done  (layer_done),
    .addr        (addr),
    .scores      (scores),
    .busy        (busy),
    .error       (error),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  typedef struct packed {
    logic [NC*SW-1:0] sc;
    logic [3:0]       idx;
    logic [SW-1:0]    score;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NC*SW-1:0] all_of(input logic [SW-1:0] v);
    logic [NC*SW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*SW +: SW] = v;
    return r;
  endfunction

  function automatic int len_of(input int k);
    return (k == 0) ? 16 : (k == 1) ? 8 : 4;
  endfunction

  // Entered on the first RUN(k) cycle; leaves on the cycle after done[k].
  // Done of the active layer is pulsed during its last run cycle (must be
  // ignored) and the other layers' done bits are raised early in WAIT.
  task automatic feed_layer(input int k);
    logic [NL-1:0] mine;
    mine = NL'(1) << k;
    for (int i = 0; i < len_of(k); i++) begin
      chk("layer_run", 32'(layer_run), 32'(mine));
      chk("addr", 32'(addr), 32'(i));
      layer_done = (i == len_of(k) - 1) ? mine : '0;
      tick();
    end
    layer_done = ~mine;
    chk("wait_run_low", 32'(layer_run), 32'd0);
    chk("wait_addr0", 32'(addr), 32'd0);
    tick();
    chk("wait_run_low", 32'(layer_run), 32'd0);
    tick();
    chk("wait_busy", 32'(busy), 32'd1);
    layer_done = mine;
    tick();
    layer_done = '0;
  endtask

  // hold_mode: 0 accept at once, 1 abort in HOLD, 2 ten cycles of backpressure
  task automatic run_inference(input int t, input int hold_mode);
    int n;
    scores       = tbl[t].sc;
    result_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_clears_error", 32'(error), 32'd0);
    for (int k = 0; k < NL; k++) feed_layer(k);
    // Scores must have been captured on ARGMAX entry.
    scores = all_of(16'h7FFF);
    n = 0;
    while (!result_valid && n < 2 * NC) begin
      chk("valid_low_in_argmax", 32'(result_valid), 32'd0);
      tick();
      n++;
    end
    chk("argmax_cycles", 32'(n), 32'(NC));
    chk("class_idx", 32'(class_idx), 32'(tbl[t].idx));
    chk("class_score", 32'(class_score), 32'(tbl[t].score));
    if (hold_mode == 1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_hold_valid", 32'(result_valid), 32'd0);
      chk("abort_hold_busy", 32'(busy), 32'd0);
      chk("abort_hold_run", 32'(layer_run), 32'd0);
      chk("abort_keeps_idx", 32'(class_idx), 32'(tbl[t].idx));
    end else begin
      if (hold_mode == 2) begin
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
          tick();
          chk("bp_valid", 32'(result_valid), 32'd1);
          chk("bp_idx", 32'(class_idx), 32'(tbl[t].idx));
          chk("bp_score", 32'(class_score), 32'(tbl[t].score));
          chk("bp_no_restart", 32'(layer_run), 32'd0);
        end
        start = 1'b0;
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk("valid_falls", 32'(result_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_keeps_idx", 32'(class_idx), 32'(tbl[t].idx));
      chk("idle_keeps_score", 32'(class_score), 32'(tbl[t].score));
      if (hold_mode == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_accepted", 32'(layer_run), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cleanup_idle", 32'(busy), 32'd0);
      end
    end
    $display("inference vec=%0d mode=%0d class_idx=%0d class_score=%h", t, hold_mode, class_idx, class_score);
  endtask

  initial begin
    tbl[0].sc = all_of(16'hFF00); tbl[0].sc[7*SW +: SW] = 16'h0300;
    tbl[0].idx = 4'd7; tbl[0].score = 16'h0300;
    tbl[1].sc = all_of(16'hFF00); tbl[1].sc[3*SW +: SW] = 16'h0080; tbl[1].sc[8*SW +: SW] = 16'h0080;
    tbl[1].idx = 4'd3; tbl[1].score = 16'h0080;
    tbl[2].sc = all_of(16'h8000);
    tbl[2].idx = 4'd0; tbl[2].score = 16'h8000;
    tbl[3].sc = all_of(16'h0000); tbl[3].sc[2*SW +: SW] = 16'h7FFF; tbl[3].sc[5*SW +: SW] = 16'h8000;
    tbl[3].idx = 4'd2; tbl[3].score = 16'h7FFF;
    tbl[4].sc = all_of(16'hFFFF); tbl[4].sc[9*SW +: SW] = 16'h0001;
    tbl[4].idx = 4'd9; tbl[4].score = 16'h0001;

    // Power-on reset.
    rst = 1'b1;
    tick();
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_run", 32'(layer_run), 32'd0);
    chk("por_valid", 32'(result_valid), 32'd0);
    chk("por_error", 32'(error), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int t = 0; t < 5; t++) run_inference(t, 0);
    run_inference(0, 2);
    run_inference(1, 1);

    // Abort in RUN(0) at addr 5; a start at addr 2 must not disturb the sequence.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      chk("abort_seq_addr", 32'(addr), 32'(i));
      chk("abort_seq_run", 32'(layer_run), 32'd1);
      start = (i == 2);
      if (i < 5) tick();
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_busy", 32'(busy), 32'd0);
    chk("abort_run_layer", 32'(layer_run), 32'd0);
    chk("abort_run_addr", 32'(addr), 32'd0);
    chk("abort_run_valid", 32'(result_valid), 32'd0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", 32'(busy), 32'd0);
    $display("abort sequence done");

    // Timeout: layer 1 never reports done.
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_layer(0);
    for (int i = 0; i < 8; i++) begin
      chk("to_addr", 32'(addr), 32'(i));
      tick();
    end
    chk("to_wait_entry_error", 32'(error), 32'd0);
    for (int j = 1; j < TO; j++) begin
      tick();
      chk("to_error_early", 32'(error), 32'd0);
      chk("to_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("to_error_set", 32'(error), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_keeps_error", 32'(error), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_error", 32'(error), 32'd0);
    chk("start_after_to_run", 32'(layer_run), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("timeout sequence done");

    // Reset held 3 cycles in the middle of RUN(1).
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_layer(0);
    tick(); tick(); tick();
    chk("pre_reset_addr", 32'(addr), 32'd3);
    rst = 1'b1;
    tick();
    chk("rst_run", 32'(layer_run), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_reset_busy", 32'(busy), 32'd0);
    $display("reset sequence done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
